// File: rtl/sm_pkg.sv
// Shared types and helpers for the sign-magnitude add arbiter.
package sm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Magnitude width of an n-bit sign-magnitude word (top bit is the sign).
  function automatic int mag_width(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/sm_add_core.sv
// Combinational sign-magnitude adder; carries out of the magnitude flag overflow.
module sm_add_core
  import sm_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         ovf
);

  localparam int M = mag_width(N);

  logic         sa;
  logic         sb;
  logic [M-1:0] ma;
  logic [M-1:0] mb;
  logic [M-1:0] mag;
  logic         sign;
  logic         carry;

  always_comb begin
    sa    = a[N-1];
    sb    = b[N-1];
    ma    = a[M-1:0];
    mb    = b[M-1:0];
    carry = 1'b0;
    mag   = '0;
    sign  = 1'b0;
    if (sa == sb) begin
      {carry, mag} = {1'b0, ma} + {1'b0, mb};
      sign         = sa;
    end else if (ma >= mb) begin
      mag  = ma - mb;
      sign = sa;
    end else begin
      mag  = mb - ma;
      sign = sb;
    end
    // Only a true zero becomes +0; a wrapped overflow keeps its sign.
    if ((mag == '0) && !carry) sign = 1'b0;
    sum = {sign, mag};
    ovf = carry;
  end

endmodule

// File: rtl/sm_add_arbiter.sv
// Round-robin arbiter that shares one sign-magnitude adder among NREQ requesters.
//
// state | meaning
// IDLE  | pick next valid requester round-robin, strobe its ready, capture operands
// CALC  | captured operands through the adder, result into response registers
// RESP  | hold response until rsp_ready
module sm_add_arbiter
  import sm_pkg::*;
#(
  parameter int N    = 4,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [N-1:0]      rsp_sum,
  output logic              rsp_ovf,
  input  logic              rsp_ready,
  output logic              busy
);

  state_t         state;
  logic [IDW-1:0] last_grant;
  logic [N-1:0]   cap_a;
  logic [N-1:0]   cap_b;
  logic [IDW-1:0] cap_id;

  logic [N-1:0]   req_a_arr [NREQ];
  logic [N-1:0]   req_b_arr [NREQ];
  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] cand;
  logic [N-1:0]   core_sum;
  logic           core_ovf;

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign req_a_arr[g] = req_a[g*N +: N];
    assign req_b_arr[g] = req_b[g*N +: N];
  end

  // Search upward from the slot after the last grant, wrapping at NREQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IDW'((int'(last_grant) + i) % NREQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if ((state == IDLE) && grant_found) req_ready[grant_idx] = 1'b1;
  end

  sm_add_core #(.N(N)) u_core (
    .a   (cap_a),
    .b   (cap_b),
    .sum (core_sum),
    .ovf (core_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= IDW'(NREQ - 1);
      cap_a      <= '0;
      cap_b      <= '0;
      cap_id     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_sum    <= '0;
      rsp_ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            cap_a      <= req_a_arr[grant_idx];
            cap_b      <= req_b_arr[grant_idx];
            cap_id     <= grant_idx;
            last_grant <= grant_idx;
            state      <= CALC;
          end
        end
        CALC: begin
          rsp_sum   <= core_sum;
          rsp_ovf   <= core_ovf;
          rsp_id    <= cap_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_sm_add_arbiter.sv
// Randomized and directed bench for sm_add_arbiter against an arithmetic/queue reference.
module tb_sm_add_arbiter;

  localparam int N    = 4;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int M    = N - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [N-1:0]      rsp_sum;
  logic              rsp_ovf;
  logic              rsp_ready;
  logic              busy;

  sm_add_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_ovf   (rsp_ovf),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: phase 0 waiting, 1 computing, 2 presenting a response.
  int             phase;
  int             ptr;
  int             exp_id;
  logic [N:0]     exp_res;
  int             grant_log[$];
  logic [NREQ-1:0] last_ready;
  logic [IDW-1:0] seen_id;
  logic [N-1:0]   seen_sum;
  logic           seen_ovf;

  // Signed integer sum; overflow when |sum| no longer fits in M bits.
  function automatic logic [N:0] ref_add(input logic [N-1:0] a, input logic [N-1:0] b);
    int va, vb, tot, absr;
    logic [N:0] r;
    va = int'(a[N-2:0]);
    vb = int'(b[N-2:0]);
    if (a[N-1]) va = -va;
    if (b[N-1]) vb = -vb;
    tot  = va + vb;
    absr = (tot < 0) ? -tot : tot;
    r[N]     = (absr >= (1 << M));
    r[N-1]   = (tot < 0);
    r[N-2:0] = M'(absr % (1 << M));
    return r;
  endfunction

  task automatic model_reset();
    phase = 0;
    ptr   = NREQ - 1;
    grant_log.delete();
  endtask

  task automatic cycle();
    logic [NREQ-1:0] exp_ready;
    int pick;
    @(negedge clk);
    exp_ready = '0;
    pick      = -1;
    if (phase == 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        int j = (ptr + k) % NREQ;
        if (pick < 0 && req_valid[j]) pick = j;
      end
      if (pick >= 0) exp_ready[pick] = 1'b1;
    end
    last_ready = req_ready;
    check("req_ready", req_ready, exp_ready);
    check("busy", busy, phase != 0);
    check("rsp_valid", rsp_valid, phase == 2);
    if (phase == 2) begin
      check("rsp_id", rsp_id, exp_id);
      check("rsp_sum", rsp_sum, exp_res[N-1:0]);
      check("rsp_ovf", rsp_ovf, exp_res[N]);
      seen_id  = rsp_id;
      seen_sum = rsp_sum;
      seen_ovf = rsp_ovf;
    end
    case (phase)
      0: if (pick >= 0) begin
           ptr     = pick;
           exp_id  = pick;
           exp_res = ref_add(req_a[pick*N +: N], req_b[pick*N +: N]);
           grant_log.push_back(pick);
           phase   = 1;
         end
      1: phase = 2;
      default: if (rsp_ready) phase = 0;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_phase(input int target, input int budget, input string tag);
    int n = 0;
    while (phase != target && n < budget) begin
      cycle();
      n++;
    end
    check(tag, phase, target);
  endtask

  task automatic send(input int id, input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic [N-1:0] want_sum, input logic want_ovf, input string tag);
    req_valid        = NREQ'(1) << id;
    req_a[id*N +: N] = a;
    req_b[id*N +: N] = b;
    run_until_phase(1, 10, {tag, "_grant"});
    req_valid = '0;
    run_until_phase(0, 10, {tag, "_done"});
    check({tag, "_id"}, seen_id, id);
    check({tag, "_sum"}, seen_sum, want_sum);
    check({tag, "_ovf"}, seen_ovf, want_ovf);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    model_reset();
    #3;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_sum", rsp_sum, 0);
    check("rst_rsp_ovf", rsp_ovf, 0);
    do_reset();

    send(0, 4'b0011, 4'b0010, 4'b0101, 1'b0, "add_pos");
    send(2, 4'b1110, 4'b0010, 4'b1100, 1'b0, "add_mixed");
    send(1, 4'b0101, 4'b1101, 4'b0000, 1'b0, "cancel");
    send(3, 4'b1000, 4'b1000, 4'b0000, 1'b0, "neg_zero");
    send(0, 4'b0110, 4'b0011, 4'b0001, 1'b1, "ovf_pos");
    send(2, 4'b1111, 4'b1001, 4'b1000, 1'b1, "ovf_neg");

    // Fairness: everyone requesting, then only 0 and 2.
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*N +: N] = N'(i + 1);
      req_b[i*N +: N] = N'(i);
    end
    req_valid = '1;
    for (int n = 0; n < 40 && grant_log.size() < 5; n++) cycle();
    check("rr_count", grant_log.size(), 5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++) check("rr_order", grant_log[i], i % NREQ);
    req_valid = 4'b0101;
    for (int n = 0; n < 40 && grant_log.size() < 8; n++) cycle();
    check("rr2_count", grant_log.size(), 8);
    for (int i = 5; i < 8 && i < grant_log.size(); i++) check("rr2_order", grant_log[i], (i % 2 == 1) ? 2 : 0);
    req_valid = '0;
    run_until_phase(0, 10, "rr_drain");

    // Back-pressure with a competing request waiting.
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    req_a[1*N +: N] = 4'b0100;
    req_b[1*N +: N] = 4'b1001;
    run_until_phase(1, 10, "bp_grant");
    req_valid = 4'b1000;
    run_until_phase(2, 5, "bp_resp");
    for (int n = 0; n < 5; n++) begin
      cycle();
      check("bp_req_ready", last_ready, 0);
      check("bp_hold_sum", seen_sum, 4'b0011);
      check("bp_hold_id", seen_id, 1);
    end
    rsp_ready = 1'b1;
    cycle();
    cycle();
    check("bp_next_grant", grant_log[$], 3);
    req_valid = '0;
    run_until_phase(0, 10, "bp_drain");

    // Asynchronous reset while computing.
    req_valid = 4'b0001;
    run_until_phase(1, 10, "rst_grant");
    req_valid = 4'b1010;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_rsp_valid", rsp_valid, 0);
    check("arst_rsp_sum", rsp_sum, 0);
    check("arst_rsp_id", rsp_id, 0);
    check("arst_rsp_ovf", rsp_ovf, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();
    check("arst_first_grant", (grant_log.size() > 0) ? grant_log[$] : -1, 1);
    req_valid = '0;
    run_until_phase(0, 10, "arst_drain");

    // Randomized traffic; requesters hold until strobed, occasionally withdraw.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && last_ready[i]) begin
          req_valid[i] = ($urandom_range(0, 1) == 1);
          req_a[i*N +: N] = N'($urandom_range(0, (1 << N) - 1));
          req_b[i*N +: N] = N'($urandom_range(0, (1 << N) - 1));
        end else if (!req_valid[i]) begin
          if ($urandom_range(0, 9) < 4) begin
            req_valid[i] = 1'b1;
            req_a[i*N +: N] = N'($urandom_range(0, (1 << N) - 1));
            req_b[i*N +: N] = N'($urandom_range(0, (1 << N) - 1));
          end
        end else if ($urandom_range(0, 19) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    run_until_phase(0, 20, "final_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
